tow_press_arbiter: RTL
======================

Name: tow_press_arbiter

Overview:
- Consumer end of the per-player press latches in the tug-of-war design.
- Samples the two latched press flags, arbitrates them, and moves the rope position one step per accepted press.
- Issues the latch clear (clr) back to the latch that was served, enforces a cooldown between presses, and detects the win condition.

Parameters:
- HALF, 8: steps from centre to either end; the rope position spans 0..2*HALF.
- POS_W, 5: width of pos; must satisfy 2^POS_W > 2*HALF.
- COOLDOWN, 8: cycles clr stays asserted after a served press; legal range >= 3 (needed to flush the synchronizer).

Ports:
- clk  input  1  system clock; every register is clocked on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- lat_l  input  1  left player latch out (held press); asynchronous to clk.
- lat_r  input  1  right player latch out; asynchronous to clk.
- start  input  1  synchronous restart-game pulse.
- clr_l  output  1  clear to the left latch; registered.
- clr_r  output  1  clear to the right latch; registered.
- step_l  output  1  one-cycle strobe: left press accepted, pos decremented.
- step_r  output  1  one-cycle strobe: right press accepted, pos incremented.
- tie  output  1  one-cycle strobe: both presses seen in the same sample.
- pos  output  POS_W  rope position; HALF is centre.
- win_l  output  1  level: left player has won (pos==0).
- win_r  output  1  level: right player has won (pos==2*HALF).

Behaviour:
- Synchronizers: lat_l and lat_r each pass through a 2-flop synchronizer, giving sl and sr. The FSM sees only sl and sr.
- FSM states: FLUSH, IDLE, COOL, WIN. The cooldown counter cnt is sized for COOLDOWN-1.
- Reset (rst_n=0 at an edge):
  - state=FLUSH, cnt=COOLDOWN-1, pos=HALF.
  - clr_l=clr_r=1.
  - step_l, step_r, tie, win_l, win_r = 0.
  - Synchronizer flops = 0.
- Priority at each edge: reset > start > FSM.
- start=1 in any state: same actions as reset except the synchronizer flops are left alone. pos=HALF, win flags=0, state=FLUSH.
- FLUSH:
  - clr_l=clr_r=1; cnt decrements each cycle.
  - When cnt==0: state=IDLE and clr_l=clr_r=0 at that edge.
- IDLE:
  - sl=1, sr=0: step_l=1 for one cycle, pos=pos-1, clr_l=1, cnt=COOLDOWN-1, state=COOL.
  - sr=1, sl=0: mirror of the above (step_r, pos+1, clr_r).
  - sl=sr=1: tie=1 for one cycle, pos unchanged, clr_l=clr_r=1, cnt=COOLDOWN-1, state=COOL.
  - sl=sr=0: hold.
- Latency: a lat_l rising edge sampled at edge k gives step_l and clr_l high after edge k+2, i.e. registered by the FSM at edge k+2.
- COOL:
  - The asserted clr line(s) are held; cnt decrements.
  - When cnt==0: the clr line(s) drop and state=IDLE.
  - A latch not being cleared stays pending and is served in the first IDLE cycle. No press is lost; the opponent does not gain a step.
- Win detect: evaluated on the pos update made in IDLE.
  - New pos==0: win_l=1, state=WIN instead of COOL.
  - New pos==2*HALF: win_r=1, state=WIN.
  - The step strobe still fires on that winning step.
- WIN:
  - clr_l=clr_r=1 held; inputs ignored; pos frozen.
  - win flag held until start or reset.
- Arithmetic: pos never leaves 0..2*HALF. No wrap is possible, because WIN is entered at both bounds.
- Held button: the latch re-sets as soon as clr drops. Result is one step per COOLDOWN+3 cycles (auto-repeat); this is intended.
- step_l, step_r and tie are mutually exclusive, and at most one of them fires per served press.

Test Plan:
- Reset with COOLDOWN=8 -> clr_l=clr_r=1 for 8 cycles after rst_n rises, then both 0; pos=8; no strobes.
- Single lat_l pulse in IDLE -> step_l high for exactly one cycle 2 edges after sampling; pos 8->7; clr_l high 8 cycles; clr_r stays 0.
- lat_l and lat_r rise on the same edge -> tie=1 for one cycle; pos stays 8; both clr lines high 8 cycles.
- lat_r asserted during left's COOL -> step_r fires on the first IDLE cycle after COOL; pos returns to 8.
- 8 separate left presses from centre -> pos reaches 0; win_l=1; 9th press gives no step_l; clr_l=clr_r=1 held.
- start pulse in WIN -> pos=8, win_l=0, FLUSH for 8 cycles, then IDLE. Also apply rst_n=0 mid-COOL -> all outputs return to their reset values on that edge.

Source files
------------

// File: rtl/tow_press_arbiter.sv
// Tug-of-war press arbiter: synchronizes the two player latch outputs,
// serves one press at a time, moves the rope, clears the served latch,
// holds a cooldown between presses and detects the win condition.
module tow_press_arbiter #(
  parameter int HALF     = 8,
  parameter int POS_W    = 5,
  parameter int COOLDOWN = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             lat_l,
  input  logic             lat_r,
  input  logic             start,
  output logic             clr_l,
  output logic             clr_r,
  output logic             step_l,
  output logic             step_r,
  output logic             tie,
  output logic [POS_W-1:0] pos,
  output logic             win_l,
  output logic             win_r
);

  localparam int CNT_W = (COOLDOWN > 2) ? $clog2(COOLDOWN) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(COOLDOWN - 1);
  localparam logic [POS_W-1:0] POS_MID  = POS_W'(HALF);
  localparam logic [POS_W-1:0] POS_MAX  = POS_W'(2 * HALF);
  localparam logic [POS_W-1:0] POS_MIN  = '0;

  typedef enum logic [1:0] {FLUSH, IDLE, COOL, WIN} state_t;

  logic meta_l, meta_r, sl, sr;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             clr_l_q, clr_l_d, clr_r_q, clr_r_d;
  logic             step_l_q, step_l_d, step_r_q, step_r_d, tie_q, tie_d;
  logic             win_l_q, win_l_d, win_r_q, win_r_d;
  logic [POS_W-1:0] pos_dec, pos_inc;

  assign pos_dec = pos_q - 1'b1;
  assign pos_inc = pos_q + 1'b1;

  // Two-flop synchronizers for the asynchronous latch outputs; start does not touch them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_l <= 1'b0;
      sl     <= 1'b0;
      meta_r <= 1'b0;
      sr     <= 1'b0;
    end else begin
      meta_l <= lat_l;
      sl     <= meta_l;
      meta_r <= lat_r;
      sr     <= meta_r;
    end
  end

  // State, counter, rope position and all registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= FLUSH;
      cnt_q    <= CNT_INIT;
      pos_q    <= POS_MID;
      clr_l_q  <= 1'b1;
      clr_r_q  <= 1'b1;
      step_l_q <= 1'b0;
      step_r_q <= 1'b0;
      tie_q    <= 1'b0;
      win_l_q  <= 1'b0;
      win_r_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pos_q    <= pos_d;
      clr_l_q  <= clr_l_d;
      clr_r_q  <= clr_r_d;
      step_l_q <= step_l_d;
      step_r_q <= step_r_d;
      tie_q    <= tie_d;
      win_l_q  <= win_l_d;
      win_r_q  <= win_r_d;
    end
  end

  // Next-state logic: start restarts the game, otherwise arbitrate / cool down / flush.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pos_d    = pos_q;
    clr_l_d  = clr_l_q;
    clr_r_d  = clr_r_q;
    step_l_d = 1'b0;
    step_r_d = 1'b0;
    tie_d    = 1'b0;
    win_l_d  = win_l_q;
    win_r_d  = win_r_q;

    if (start) begin
      state_d = FLUSH;
      cnt_d   = CNT_INIT;
      pos_d   = POS_MID;
      clr_l_d = 1'b1;
      clr_r_d = 1'b1;
      win_l_d = 1'b0;
      win_r_d = 1'b0;
    end else begin
      unique case (state_q)
        FLUSH: begin
          clr_l_d = 1'b1;
          clr_r_d = 1'b1;
          if (cnt_q == '0) begin
            state_d = IDLE;
            clr_l_d = 1'b0;
            clr_r_d = 1'b0;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        IDLE: begin
          if (sl || sr) begin
            cnt_d   = CNT_INIT;
            state_d = COOL;
            if (sl && sr) begin
              tie_d   = 1'b1;
              clr_l_d = 1'b1;
              clr_r_d = 1'b1;
            end else if (sl) begin
              step_l_d = 1'b1;
              pos_d    = pos_dec;
              clr_l_d  = 1'b1;
              if (pos_dec == POS_MIN) begin
                win_l_d = 1'b1;
                state_d = WIN;
                clr_r_d = 1'b1;
              end
            end else begin
              step_r_d = 1'b1;
              pos_d    = pos_inc;
              clr_r_d  = 1'b1;
              if (pos_inc == POS_MAX) begin
                win_r_d = 1'b1;
                state_d = WIN;
                clr_l_d = 1'b1;
              end
            end
          end
        end
        COOL: begin
          if (cnt_q == '0) begin
            state_d = IDLE;
            clr_l_d = 1'b0;
            clr_r_d = 1'b0;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        WIN: begin
          clr_l_d = 1'b1;
          clr_r_d = 1'b1;
        end
        default: state_d = FLUSH;
      endcase
    end
  end

  assign clr_l  = clr_l_q;
  assign clr_r  = clr_r_q;
  assign step_l = step_l_q;
  assign step_r = step_r_q;
  assign tie    = tie_q;
  assign pos    = pos_q;
  assign win_l  = win_l_q;
  assign win_r  = win_r_q;

endmodule
